data_cache_ctrl: RTL and testbench

//  Parametrised direct-mapped, write-back, write-allocate data cache between the cpu (READ/WRITE/ALURESULT/DATAOUT/DATAIN/BUSYWAIT) and block-wide data memory.

---
 rtl/data_cache_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with block-wide memory
// interface and saturating hit/miss statistics counters.
module data_cache_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned WORDS  = 4,
   parameter int unsigned SETS   = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            READ,
   input  logic                            WRITE,
   input  logic [ADDR_W-1:0]               ADDRESS,
   input  logic [DATA_W-1:0]               WRITEDATA,
   output logic [DATA_W-1:0]               READDATA,
   output logic                            BUSYWAIT,
   output logic                            MEM_READ,
   output logic                            MEM_WRITE,
   output logic [ADDR_W-$clog2(WORDS)-1:0] MEM_ADDRESS,
   output logic [DATA_W*WORDS-1:0]         MEM_WRITEDATA,
   input  logic [DATA_W*WORDS-1:0]         MEM_READDATA,
   input  logic                            MEM_BUSYWAIT,
   output logic [CNT_W-1:0]                HIT_COUNT,
   output logic [CNT_W-1:0]                MISS_COUNT
);

   localparam int unsigned OFF_W  = $clog2(WORDS);
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned BLK_W  = ADDR_W - OFF_W;
   localparam int unsigned LINE_W = DATA_W * WORDS;

   typedef enum logic [1:0] {StIdle, StWriteBack, StFetch, StUpdate} state_e;

   state_e              state_q, state_d;
   logic                first_q, first_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [BLK_W-1:0]    mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
   logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
   logic                miss_pend_q, miss_pend_d;
   logic [SETS-1:0]     valid_q, valid_d;
   logic [SETS-1:0]     dirty_q, dirty_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   // Tag and data arrays carry no reset; valid bits qualify them.
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [LINE_W-1:0]   line_q [SETS];

   logic [TAG_W-1:0]    addr_tag;
   logic [IDX_W-1:0]    addr_idx;
   logic [OFF_W-1:0]    addr_off;
   logic                req, wr, rd, hit, idle_hit;
   logic [DATA_W-1:0]   rd_word;

   assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
   assign addr_idx = ADDRESS[OFF_W +: IDX_W];
   assign addr_off = ADDRESS[OFF_W-1:0];
   assign req      = READ | WRITE;
   assign wr       = WRITE;
   assign rd       = READ & ~WRITE;
   assign hit      = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
   assign idle_hit = (state_q == StIdle) & req & hit;
   assign rd_word  = line_q[addr_idx][addr_off*DATA_W +: DATA_W];

   // Reset forces the stall low at once even while the cpu still holds its request.
   assign BUSYWAIT      = RESET & req & ~((state_q == StIdle) & hit);
   assign READDATA      = ((state_q == StIdle) & rd & hit) ? rd_word : '0;
   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;
   assign HIT_COUNT     = hit_cnt_q;
   assign MISS_COUNT    = miss_cnt_q;

   always_comb begin
      state_d     = state_q;
      first_d     = 1'b0;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      miss_tag_d  = miss_tag_q;
      miss_idx_d  = miss_idx_q;
      miss_pend_d = miss_pend_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req && !hit) begin
               miss_cnt_d  = (miss_cnt_q == {CNT_W{1'b1}}) ? miss_cnt_q : miss_cnt_q + 1'b1;
               miss_pend_d = 1'b1;
               miss_tag_d  = addr_tag;
               miss_idx_d  = addr_idx;
               first_d     = 1'b1;
               if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                  state_d     = StWriteBack;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[addr_idx], addr_idx};
                  mem_wdata_d = line_q[addr_idx];
               end else begin
                  state_d    = StFetch;
                  mem_read_d = 1'b1;
                  mem_addr_d = {addr_tag, addr_idx};
               end
            end else if (idle_hit) begin
               // The hit that completes a missed access is not counted as a hit.
               if (!miss_pend_q) begin
                  hit_cnt_d = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + 1'b1;
               end
               miss_pend_d = 1'b0;
               if (wr) begin
                  dirty_d[addr_idx] = 1'b1;
               end
            end
         end
         StWriteBack: begin
            if (!first_q && !MEM_BUSYWAIT) begin
               state_d     = StFetch;
               first_d     = 1'b1;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {miss_tag_q, miss_idx_q};
            end
         end
         StFetch: begin
            if (!first_q && !MEM_BUSYWAIT) begin
               state_d    = StUpdate;
               mem_read_d = 1'b0;
            end
         end
         StUpdate: begin
            state_d             = StIdle;
            valid_d[miss_idx_q] = 1'b1;
            dirty_d[miss_idx_q] = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= StIdle;
         first_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         miss_tag_q  <= '0;
         miss_idx_q  <= '0;
         miss_pend_q <= 1'b0;
         valid_q     <= '0;
         dirty_q     <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         miss_tag_q  <= miss_tag_d;
         miss_idx_q  <= miss_idx_d;
         miss_pend_q <= miss_pend_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (state_q == StUpdate) begin
         line_q[miss_idx_q] <= MEM_READDATA;
         tag_q[miss_idx_q]  <= miss_tag_q;
      end else if (idle_hit && wr) begin
         line_q[addr_idx][addr_off*DATA_W +: DATA_W] <= WRITEDATA;
      end
   end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: a latency-5 block memory plus a word-level
// reference model of cache contents, residency and expected stall lengths.
module tb_data_cache_ctrl;

   localparam int unsigned LAT = 5;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = '0;
   logic [7:0]  WRITEDATA = '0;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;
   logic [15:0] HIT_COUNT;
   logic [15:0] MISS_COUNT;

   logic [7:0]  s_readdata;
   logic        s_busywait, s_mem_read, s_mem_write;
   logic [5:0]  s_mem_address;
   logic [31:0] s_mem_writedata;
   logic [3:0]  s_hit_count, s_miss_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   data_cache_ctrl dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
   );

   // Narrow-counter copy fed identical stimulus; only its counters are examined.
   data_cache_ctrl #(.CNT_W(4)) dut_sat (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(s_readdata), .BUSYWAIT(s_busywait),
      .MEM_READ(s_mem_read), .MEM_WRITE(s_mem_write), .MEM_ADDRESS(s_mem_address),
      .MEM_WRITEDATA(s_mem_writedata), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(s_hit_count), .MISS_COUNT(s_miss_count)
   );

   function automatic logic [31:0] init_word(input int blk);
      return 32'h44332211 + blk * 32'h01020305;
   endfunction

   // Block memory: busy from the 2nd request cycle, finishes on the 5th cycle.
   logic [31:0] mem [64];
   int          mcnt;
   logic [1:0]  mkind_q;
   logic [1:0]  mkind;
   int          mnext;
   assign mkind = {MEM_READ, MEM_WRITE};
   assign mnext = (mkind == 2'b00) ? 0 : (mkind != mkind_q) ? 1 : mcnt + 1;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mcnt         <= 0;
         mkind_q      <= 2'b00;
         MEM_BUSYWAIT <= 1'b0;
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else begin
         mcnt         <= mnext;
         mkind_q      <= mkind;
         MEM_BUSYWAIT <= (mkind != 2'b00) && (mnext < int'(LAT) - 1);
         if (mkind != 2'b00 && mnext == int'(LAT) - 1) begin
            if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            else           MEM_READDATA <= mem[MEM_ADDRESS];
         end
      end
   end

   // Memory traffic monitor.
   int          rd_cyc = 0;
   int          wr_cyc = 0;
   int          both_cyc = 0;
   logic [5:0]  rd_addr_last = '0;
   logic [5:0]  wb_addr_last = '0;
   logic [31:0] wb_data_last = '0;
   always @(posedge CLK) begin
      if (MEM_READ) begin
         rd_cyc       <= rd_cyc + 1;
         rd_addr_last <= MEM_ADDRESS;
      end
      if (MEM_WRITE) begin
         wr_cyc       <= wr_cyc + 1;
         wb_addr_last <= MEM_ADDRESS;
         wb_data_last <= MEM_WRITEDATA;
      end
      if (MEM_READ && MEM_WRITE) both_cyc <= both_cyc + 1;
   end

   // Reference model: cpu-visible bytes plus which block each set holds.
   logic [7:0] ref_word [256];
   bit         ref_valid [8];
   bit         ref_dirty [8];
   int         ref_tag [8];
   int         ref_hits;
   int         ref_misses;

   task automatic ref_reset();
      logic [31:0] w;
      for (int a = 0; a < 256; a++) begin
         w = init_word(a / 4);
         ref_word[a] = w[(a % 4)*8 +: 8];
      end
      for (int s = 0; s < 8; s++) begin
         ref_valid[s] = 1'b0;
         ref_dirty[s] = 1'b0;
         ref_tag[s]   = 0;
      end
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   task automatic ref_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                             output int exp_stall, output logic [7:0] exp_rd,
                             output bit exp_wb, output logic [5:0] exp_wb_addr,
                             output logic [31:0] exp_wb_data);
      int idx, tag;
      idx = int'(a) / 4 % 8;
      tag = int'(a) / 32;
      exp_wb      = 1'b0;
      exp_wb_addr = '0;
      exp_wb_data = '0;
      if (ref_valid[idx] && ref_tag[idx] == tag) begin
         exp_stall = 0;
         ref_hits++;
      end else begin
         ref_misses++;
         if (ref_valid[idx] && ref_dirty[idx]) begin
            exp_wb      = 1'b1;
            exp_wb_addr = 6'(ref_tag[idx] * 8 + idx);
            for (int w = 0; w < 4; w++)
               exp_wb_data[w*8 +: 8] = ref_word[ref_tag[idx]*32 + idx*4 + w];
            exp_stall = 2 * int'(LAT) + 2;
         end else begin
            exp_stall = int'(LAT) + 2;
         end
         ref_valid[idx] = 1'b1;
         ref_dirty[idx] = 1'b0;
         ref_tag[idx]   = tag;
      end
      exp_rd = ref_word[a];
      if (wr) begin
         ref_word[a]    = d;
         ref_dirty[idx] = 1'b1;
      end
   endtask

   // Drives one cpu access and holds it until it completes (bounded).
   task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output int stalls, output logic [7:0] rdata);
      @(negedge CLK);
      READ      = !wr;
      WRITE     = wr;
      ADDRESS   = a;
      WRITEDATA = d;
      #1;
      stalls = 0;
      while (BUSYWAIT && stalls <= 100) begin
         stalls++;
         @(negedge CLK);
         #1;
      end
      rdata = READDATA;
      @(posedge CLK);
      #1;
      READ  = 1'b0;
      WRITE = 1'b0;
   endtask

   int          st, e_st;
   logic [7:0]  rd, e_rd;
   bit          e_wb;
   logic [5:0]  e_wa;
   logic [31:0] e_wd;
   int          rd0, wr0;

   task automatic test_reset();
      #2 RESET = 1'b0;
      #1;
      ref_reset();
      checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
      checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin errors++; $display("FAIL reset_mem_req got %b want 00", {MEM_READ, MEM_WRITE}); end
      checks++; if (READDATA !== 8'h00) begin errors++; $display("FAIL reset_readdata got %h want 00", READDATA); end
      checks++; if ({HIT_COUNT, MISS_COUNT} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h/%h want 0/0", HIT_COUNT, MISS_COUNT); end
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_clean_miss();
      rd0 = rd_cyc; wr0 = wr_cyc;
      ref_access(1'b0, 8'h00, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h00, 8'h00, st, rd);
      checks++; if (st !== 7 || st !== e_st) begin errors++; $display("FAIL clean_miss_stall got %0d want 7", st); end
      checks++; if (rd !== 8'h11) begin errors++; $display("FAIL clean_miss_data got %h want 11", rd); end
      checks++; if (rd_addr_last !== 6'h00 || rd_cyc - rd0 !== int'(LAT)) begin errors++; $display("FAIL clean_miss_fetch got addr %h cycles %0d want 00 %0d", rd_addr_last, rd_cyc - rd0, LAT); end
      checks++; if (wr_cyc !== wr0) begin errors++; $display("FAIL clean_miss_no_wb got %0d write cycles want 0", wr_cyc - wr0); end
      checks++; if (MISS_COUNT !== 16'd1) begin errors++; $display("FAIL clean_miss_count got %0d want 1", MISS_COUNT); end
   endtask

   task automatic test_read_hit();
      rd0 = rd_cyc; wr0 = wr_cyc;
      ref_access(1'b0, 8'h01, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h01, 8'h00, st, rd);
      checks++; if (st !== 0) begin errors++; $display("FAIL hit_stall got %0d want 0", st); end
      checks++; if (rd !== 8'h22) begin errors++; $display("FAIL hit_data got %h want 22", rd); end
      checks++; if (rd_cyc + wr_cyc !== rd0 + wr0) begin errors++; $display("FAIL hit_no_mem got %0d mem cycles want 0", rd_cyc + wr_cyc - rd0 - wr0); end
      checks++; if (HIT_COUNT !== 16'd1) begin errors++; $display("FAIL hit_count got %0d want 1", HIT_COUNT); end
   endtask

   task automatic test_write_hit();
      rd0 = rd_cyc; wr0 = wr_cyc;
      ref_access(1'b1, 8'h02, 8'hAB, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b1, 8'h02, 8'hAB, st, rd);
      checks++; if (st !== 0) begin errors++; $display("FAIL write_hit_stall got %0d want 0", st); end
      checks++; if (rd_cyc + wr_cyc !== rd0 + wr0) begin errors++; $display("FAIL write_hit_no_mem got %0d mem cycles want 0", rd_cyc + wr_cyc - rd0 - wr0); end
      ref_access(1'b0, 8'h02, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h02, 8'h00, st, rd);
      checks++; if (rd !== 8'hAB || st !== 0) begin errors++; $display("FAIL write_hit_readback got %h stall %0d want ab 0", rd, st); end
   endtask

   task automatic test_dirty_evict();
      rd0 = rd_cyc; wr0 = wr_cyc;
      ref_access(1'b0, 8'h20, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h20, 8'h00, st, rd);
      checks++; if (wb_addr_last !== 6'h00 || wb_data_last !== 32'h44AB2211 || wr_cyc - wr0 !== int'(LAT)) begin
         errors++; $display("FAIL evict_wb got %h/%h want 00/44ab2211", wb_addr_last, wb_data_last); end
      checks++; if (rd_addr_last !== 6'h08 || rd_cyc - rd0 !== int'(LAT)) begin errors++; $display("FAIL evict_fetch got %h want 08", rd_addr_last); end
      checks++; if (st !== 2 * int'(LAT) + 2) begin errors++; $display("FAIL evict_stall got %0d want %0d", st, 2 * LAT + 2); end
      checks++; if (rd !== e_rd) begin errors++; $display("FAIL evict_data got %h want %h", rd, e_rd); end
      checks++; if (MISS_COUNT !== 16'd2) begin errors++; $display("FAIL evict_miss_count got %0d want 2", MISS_COUNT); end
      checks++; if (both_cyc !== 0) begin errors++; $display("FAIL evict_req_overlap got %0d want 0", both_cyc); end
   endtask

   task automatic test_random();
      bit         wr;
      logic [7:0] a, d;
      for (int n = 0; n < 80; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 127));
         d  = 8'($urandom);
         wr0 = wr_cyc;
         ref_access(wr, a, d, e_st, e_rd, e_wb, e_wa, e_wd);
         access(wr, a, d, st, rd);
         checks++; if (st !== e_st) begin errors++; $display("FAIL rand_stall addr %h got %0d want %0d", a, st, e_st); end
         if (!wr) begin
            checks++; if (rd !== e_rd) begin errors++; $display("FAIL rand_read addr %h got %h want %h", a, rd, e_rd); end
         end
         if (e_wb) begin
            checks++; if (wb_addr_last !== e_wa || wb_data_last !== e_wd || wr_cyc == wr0) begin
               errors++; $display("FAIL rand_wb got %h/%h want %h/%h", wb_addr_last, wb_data_last, e_wa, e_wd); end
         end
      end
      checks++; if (HIT_COUNT !== 16'(ref_hits) || MISS_COUNT !== 16'(ref_misses)) begin
         errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", HIT_COUNT, MISS_COUNT, ref_hits, ref_misses); end
      checks++; if (both_cyc !== 0) begin errors++; $display("FAIL rand_req_overlap got %0d want 0", both_cyc); end
   endtask

   task automatic test_saturate();
      ref_access(1'b0, 8'h00, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h00, 8'h00, st, rd);
      for (int n = 0; n < 20; n++) begin
         ref_access(1'b0, 8'(n % 4), 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
         access(1'b0, 8'(n % 4), 8'h00, st, rd);
      end
      checks++; if (s_hit_count !== 4'd15) begin errors++; $display("FAIL sat_hit got %0d want 15", s_hit_count); end
      checks++; if (s_miss_count !== 4'((ref_misses > 15) ? 15 : ref_misses)) begin
         errors++; $display("FAIL sat_miss got %0d want %0d", s_miss_count, (ref_misses > 15) ? 15 : ref_misses); end
      checks++; if (HIT_COUNT !== 16'(ref_hits)) begin errors++; $display("FAIL wide_hit got %0d want %0d", HIT_COUNT, ref_hits); end
      ref_access(1'b0, 8'h01, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h01, 8'h00, st, rd);
      checks++; if (s_hit_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", s_hit_count); end
   endtask

   task automatic test_reset_mid_miss();
      int waited;
      @(negedge CLK);
      READ    = 1'b1;
      ADDRESS = 8'hE4;
      waited  = 0;
      while (!MEM_READ && waited < 40) begin
         @(negedge CLK);
         waited++;
      end
      checks++; if (!MEM_READ) begin errors++; $display("FAIL midmiss_fetch got MEM_READ 0 want 1"); end
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checks++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
         errors++; $display("FAIL midmiss_reset got rd %b bw %b want 0 0", MEM_READ, BUSYWAIT); end
      READ = 1'b0;
      ref_reset();
      @(negedge CLK);
      RESET = 1'b1;
      ref_access(1'b0, 8'h00, 8'h00, e_st, e_rd, e_wb, e_wa, e_wd);
      access(1'b0, 8'h00, 8'h00, st, rd);
      checks++; if (st !== int'(LAT) + 2 || rd !== 8'h11) begin
         errors++; $display("FAIL midmiss_remiss got stall %0d data %h want 7 11", st, rd); end
      checks++; if (MISS_COUNT !== 16'd1 || HIT_COUNT !== 16'd0) begin
         errors++; $display("FAIL midmiss_counters got %0d/%0d want 0/1", HIT_COUNT, MISS_COUNT); end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_read_hit();
      test_write_hit();
      test_dirty_evict();
      test_random();
      test_saturate();
      test_reset_mid_miss();
      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
